// File: rtl/controlador_acessos_pkg.sv
// Shared definitions for the memoria request sequencer: widths, FSM encodings,
// the request record carried through the FIFO and the saturating counter helper.
package controlador_acessos_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W;

    localparam logic [7:0] CNT_SAT = 8'd255;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        logic              wren;
        logic [ADDR_W-1:0] endereco;
        logic [DATA_W-1:0] data;
    } req_t;

    // Statistics stop at CNT_SAT instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == CNT_SAT) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/controlador_acessos_fifo_requisicoes.sv
// Request queue between the processor handshake and the sequencer FSM.
// Head is visible combinationally; a separate count tells full from empty.
module fifo_requisicoes #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty gate the requests so the queue never overwrites or underflows.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/controlador_acessos.sv
// Sequencer that queues processor requests and issues them to memoria one at a
// time, waiting for a cache or main-memory hit or a timeout before responding.
module controlador_acessos
    import controlador_acessos_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_wren_in,
    input  logic [4:0]  req_endereco_in,
    input  logic [7:0]  req_data_in,
    output logic        mem_wren_out,
    output logic [4:0]  mem_endereco_out,
    output logic [7:0]  mem_data_out,
    input  logic [7:0]  mem_q_in,
    input  logic        mem_hit_cache_in,
    input  logic        mem_hit_memPrin_in,
    output logic        resp_valid_out,
    output logic [7:0]  resp_data_out,
    output logic        resp_hit_cache_out,
    output logic        resp_erro_out,
    output logic        busy_out,
    output logic [7:0]  cont_hits_out,
    output logic [7:0]  cont_misses_out
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [1:0]        r_state;
    req_t              r_txn;
    logic [WAIT_W-1:0] r_wait;
    logic              r_mem_wren;
    logic [7:0]        r_cap_data;
    logic              r_cap_hit;
    logic              r_cap_erro;
    logic              r_resp_valid;
    logic [7:0]        r_resp_data;
    logic              r_resp_hit;
    logic              r_resp_erro;
    logic [7:0]        r_hits;
    logic [7:0]        r_misses;

    req_t              w_req_in;
    req_t              w_fifo_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_fifo_push;
    logic              w_fifo_pop;

    assign w_req_in    = {req_wren_in, req_endereco_in, req_data_in};
    assign w_fifo_push = req_valid_in && !w_fifo_full;
    assign w_fifo_pop  = (r_state == ST_IDLE) && !w_fifo_empty;

    fifo_requisicoes #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .i_clock (clock_in),
        .i_reset (reset_in),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_data  (w_req_in),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // The transaction register doubles as the mem_* address/data drivers, so
    // they naturally hold their last value between transactions.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state      <= ST_IDLE;
            r_txn        <= '0;
            r_wait       <= '0;
            r_mem_wren   <= 1'b0;
            r_cap_data   <= '0;
            r_cap_hit    <= 1'b0;
            r_cap_erro   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_erro  <= 1'b0;
            r_hits       <= '0;
            r_misses     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_txn      <= w_fifo_head;
                        r_mem_wren <= w_fifo_head.wren;
                        r_wait     <= '0;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Result is parked in r_cap_* so resp_* only change on the pulse.
                    if (mem_hit_cache_in) begin
                        r_cap_data <= r_txn.wren ? r_txn.data : mem_q_in;
                        r_cap_hit  <= 1'b1;
                        r_cap_erro <= 1'b0;
                        r_hits     <= sat_inc(r_hits);
                        r_mem_wren <= 1'b0;
                        r_state    <= ST_RESP;
                    end else if (mem_hit_memPrin_in) begin
                        r_cap_data <= r_txn.wren ? r_txn.data : mem_q_in;
                        r_cap_hit  <= 1'b0;
                        r_cap_erro <= 1'b0;
                        r_misses   <= sat_inc(r_misses);
                        r_mem_wren <= 1'b0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                        if (r_wait == WAIT_LAST) begin
                            r_cap_data <= '0;
                            r_cap_hit  <= 1'b0;
                            r_cap_erro <= 1'b1;
                            r_misses   <= sat_inc(r_misses);
                            r_mem_wren <= 1'b0;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= r_cap_data;
                    r_resp_hit   <= r_cap_hit;
                    r_resp_erro  <= r_cap_erro;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_out      = !w_fifo_full;
    assign busy_out           = (r_state != ST_IDLE) || !w_fifo_empty;
    assign mem_wren_out       = r_mem_wren;
    assign mem_endereco_out   = r_txn.endereco;
    assign mem_data_out       = r_txn.data;
    assign resp_valid_out     = r_resp_valid;
    assign resp_data_out      = r_resp_data;
    assign resp_hit_cache_out = r_resp_hit;
    assign resp_erro_out      = r_resp_erro;
    assign cont_hits_out      = r_hits;
    assign cont_misses_out    = r_misses;

endmodule

// File: tb/tb_controlador_acessos.sv
// Bench for controlador_acessos: directed scenarios plus a random phase, with a
// timeline-based reference model (pop edge, WAIT index, response edge).
module tb_controlador_acessos;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic       clock_in = 1'b0;
    logic       reset_in;
    logic       req_valid_in;
    logic       req_ready_out;
    logic       req_wren_in;
    logic [4:0] req_endereco_in;
    logic [7:0] req_data_in;
    logic       mem_wren_out;
    logic [4:0] mem_endereco_out;
    logic [7:0] mem_data_out;
    logic [7:0] mem_q_in;
    logic       mem_hit_cache_in;
    logic       mem_hit_memPrin_in;
    logic       resp_valid_out;
    logic [7:0] resp_data_out;
    logic       resp_hit_cache_out;
    logic       resp_erro_out;
    logic       busy_out;
    logic [7:0] cont_hits_out;
    logic [7:0] cont_misses_out;

    controlador_acessos #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock_in           (clock_in),
        .reset_in           (reset_in),
        .req_valid_in       (req_valid_in),
        .req_ready_out      (req_ready_out),
        .req_wren_in        (req_wren_in),
        .req_endereco_in    (req_endereco_in),
        .req_data_in        (req_data_in),
        .mem_wren_out       (mem_wren_out),
        .mem_endereco_out   (mem_endereco_out),
        .mem_data_out       (mem_data_out),
        .mem_q_in           (mem_q_in),
        .mem_hit_cache_in   (mem_hit_cache_in),
        .mem_hit_memPrin_in (mem_hit_memPrin_in),
        .resp_valid_out     (resp_valid_out),
        .resp_data_out      (resp_data_out),
        .resp_hit_cache_out (resp_hit_cache_out),
        .resp_erro_out      (resp_erro_out),
        .busy_out           (busy_out),
        .cont_hits_out      (cont_hits_out),
        .cont_misses_out    (cont_misses_out)
    );

    always #5 clock_in = ~clock_in;

    // lat = WAIT index on which memoria answers (beyond MAX_WAIT means never);
    // kind 0 = cache hit, 1 = main-memory hit, 2 = both hit lines high.
    typedef struct {
        logic       wren;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] qval;
        int         lat;
        int         kind;
    } txn_t;

    txn_t       offerQ[$];
    txn_t       pendQ[$];
    txn_t       cur;
    bit         curActive;
    int         curP;
    int         nextFree;
    int         cyc;
    logic       eValid, eHit, eErr, eMemWren, capHit, capErr;
    logic [7:0] eData, capData, eMemData;
    logic [4:0] eMemAddr;
    int         eHits, eMiss;
    int         checks, failures;
    int         offerPct;
    int         errSeen;
    bit         noise, holding, pushNow;

    function automatic int keff(input int lat);
        return (lat > MAX_WAIT) ? MAX_WAIT : lat;
    endfunction

    function automatic int satInc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic txn_t makeTxn(input logic wren, input logic [4:0] addr, input logic [7:0] data,
                                     input logic [7:0] qval, input int lat, input int kind);
        txn_t t;
        t.wren = wren;
        t.addr = addr;
        t.data = data;
        t.qval = qval;
        t.lat  = lat;
        t.kind = kind;
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        offerQ.delete();
        pendQ.delete();
        curActive = 0;
        curP      = 0;
        nextFree  = 0;
        cyc       = 0;
        holding   = 0;
        eValid    = 1'b0;
        eData     = 8'h00;
        eHit      = 1'b0;
        eErr      = 1'b0;
        eMemWren  = 1'b0;
        eMemAddr  = 5'h00;
        eMemData  = 8'h00;
        capData   = 8'h00;
        capHit    = 1'b0;
        capErr    = 1'b0;
        eHits     = 0;
        eMiss     = 0;
    endtask

    task automatic checkOutput();
        if (resp_valid_out === 1'b1 && resp_erro_out === 1'b1) errSeen++;
        check("req_ready",   32'(req_ready_out),      32'(pendQ.size() < DEPTH));
        check("busy",        32'(busy_out),           32'(curActive || pendQ.size() > 0));
        check("mem_wren",    32'(mem_wren_out),       32'(eMemWren));
        check("mem_addr",    32'(mem_endereco_out),   32'(eMemAddr));
        check("mem_data",    32'(mem_data_out),       32'(eMemData));
        check("resp_valid",  32'(resp_valid_out),     32'(eValid));
        check("resp_data",   32'(resp_data_out),      32'(eData));
        check("resp_hit",    32'(resp_hit_cache_out), 32'(eHit));
        check("resp_erro",   32'(resp_erro_out),      32'(eErr));
        check("cont_hits",   32'(cont_hits_out),      32'(eHits));
        check("cont_misses", 32'(cont_misses_out),    32'(eMiss));
    endtask

    task automatic applyStimulus();
        bit inWait;
        int j;
        if (offerQ.size() > 0 && (holding || $urandom_range(99) < offerPct)) begin
            req_valid_in    = 1'b1;
            req_wren_in     = offerQ[0].wren;
            req_endereco_in = offerQ[0].addr;
            req_data_in     = offerQ[0].data;
            pushNow         = (pendQ.size() < DEPTH);
            holding         = !pushNow;
        end else begin
            req_valid_in    = 1'b0;
            req_wren_in     = 1'($urandom);
            req_endereco_in = 5'($urandom);
            req_data_in     = 8'($urandom);
            pushNow         = 0;
            holding         = 0;
        end
        mem_q_in           = 8'($urandom);
        mem_hit_cache_in   = 1'b0;
        mem_hit_memPrin_in = 1'b0;
        inWait = curActive && (cyc > curP) && (cyc <= curP + keff(cur.lat));
        if (inWait) begin
            j = cyc - curP;
            if (j == cur.lat) begin
                mem_q_in           = cur.qval;
                mem_hit_cache_in   = (cur.kind != 1);
                mem_hit_memPrin_in = (cur.kind != 0);
            end
        end else if (noise) begin
            mem_hit_cache_in   = ($urandom_range(3) == 0);
            mem_hit_memPrin_in = ($urandom_range(3) == 0);
        end
    endtask

    // Expected effects of the coming edge, derived from the transaction timeline.
    task automatic advanceModel();
        int e;
        int k;
        e = cyc + 1;
        eValid = 1'b0;
        if (curActive) begin
            k = keff(cur.lat);
            if (e == curP + k + 1) begin
                if (cur.lat <= MAX_WAIT) begin
                    capData = cur.wren ? cur.data : cur.qval;
                    capHit  = (cur.kind != 1);
                    capErr  = 1'b0;
                    if (capHit) eHits = satInc(eHits);
                    else        eMiss = satInc(eMiss);
                end else begin
                    capData = 8'h00;
                    capHit  = 1'b0;
                    capErr  = 1'b1;
                    eMiss   = satInc(eMiss);
                end
                eMemWren = 1'b0;
            end else if (e == curP + k + 2) begin
                eValid    = 1'b1;
                eData     = capData;
                eHit      = capHit;
                eErr      = capErr;
                curActive = 0;
                nextFree  = e + 1;
            end
        end
        if (!curActive && pendQ.size() > 0 && e >= nextFree) begin
            cur       = pendQ.pop_front();
            curActive = 1;
            curP      = e;
            eMemWren  = cur.wren;
            eMemAddr  = cur.addr;
            eMemData  = cur.data;
        end
        if (pushNow) begin
            pendQ.push_back(offerQ.pop_front());
        end
    endtask

    task automatic step();
        checkOutput();
        applyStimulus();
        @(posedge clock_in);
        advanceModel();
        cyc++;
        #1;
    endtask

    task automatic applyReset(input int n);
        reset_in           = 1'b1;
        req_valid_in       = 1'b0;
        mem_hit_cache_in   = 1'b0;
        mem_hit_memPrin_in = 1'b0;
        mem_q_in           = 8'($urandom);
        repeat (n) @(posedge clock_in);
        #1;
        reset_in = 1'b0;
        modelReset();
    endtask

    task automatic runUntilDrained(input string tag, input int budget);
        int n;
        n = 0;
        while ((offerQ.size() > 0 || pendQ.size() > 0 || curActive) && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        check({tag, "_drained"}, 32'(busy_out), 32'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        offerPct        = 100;
        noise           = 0;
        errSeen         = 0;
        req_wren_in     = 1'b0;
        req_endereco_in = 5'h00;
        req_data_in     = 8'h00;
        applyReset(2);

        $display("[TB] reset state");
        check("rst_ready",  32'(req_ready_out),   32'(1));
        check("rst_busy",   32'(busy_out),        32'(0));
        check("rst_valid",  32'(resp_valid_out),  32'(0));
        check("rst_hits",   32'(cont_hits_out),   32'(0));
        check("rst_misses", 32'(cont_misses_out), 32'(0));

        $display("[TB] single read, cache hit on first WAIT cycle");
        offerQ.push_back(makeTxn(1'b0, 5'h03, 8'h00, 8'hA5, 1, 0));
        runUntilDrained("t1", 50);
        check("t1_data",   32'(resp_data_out),      32'(8'hA5));
        check("t1_hitflg", 32'(resp_hit_cache_out), 32'(1));
        check("t1_hits",   32'(cont_hits_out),      32'(1));

        $display("[TB] write, main-memory hit on third WAIT cycle");
        offerQ.push_back(makeTxn(1'b1, 5'h1F, 8'h3C, 8'hEE, 3, 1));
        runUntilDrained("t2", 50);
        check("t2_data",   32'(resp_data_out),      32'(8'h3C));
        check("t2_hitflg", 32'(resp_hit_cache_out), 32'(0));
        check("t2_misses", 32'(cont_misses_out),    32'(1));

        $display("[TB] five back-to-back requests into a stalled memoria");
        noise = 1;
        for (int i = 0; i < 5; i++) begin
            offerQ.push_back(makeTxn(i[0], 5'(i + 8), 8'(8'h10 + i), 8'(8'hC0 + i), 5, 0));
        end
        runUntilDrained("t3", 200);
        check("t3_hits", 32'(cont_hits_out), 32'(6));

        $display("[TB] timeout followed by a normal request");
        errSeen = 0;
        offerQ.push_back(makeTxn(1'b0, 5'h07, 8'h00, 8'h99, MAX_WAIT + 1, 0));
        offerQ.push_back(makeTxn(1'b0, 5'h08, 8'h00, 8'h5A, 2, 0));
        runUntilDrained("t4", 100);
        check("t4_erro_seen", 32'(errSeen),         32'(1));
        check("t4_misses",    32'(cont_misses_out), 32'(2));
        check("t4_data",      32'(resp_data_out),   32'(8'h5A));

        $display("[TB] reset during WAIT with two requests queued");
        for (int i = 0; i < 3; i++) begin
            offerQ.push_back(makeTxn(1'b1, 5'(i + 20), 8'(8'h70 + i), 8'h00, MAX_WAIT + 1, 0));
        end
        for (int i = 0; i < 20; i++) begin
            if (curActive && cyc >= curP + 2 && pendQ.size() == 2) break;
            step();
        end
        check("t5_queued", 32'(busy_out), 32'(1));
        applyReset(1);
        check("t5_ready",  32'(req_ready_out),   32'(1));
        check("t5_busy",   32'(busy_out),        32'(0));
        check("t5_wren",   32'(mem_wren_out),    32'(0));
        check("t5_valid",  32'(resp_valid_out),  32'(0));
        check("t5_hits",   32'(cont_hits_out),   32'(0));
        check("t5_misses", 32'(cont_misses_out), 32'(0));
        for (int i = 0; i < 12; i++) step();

        $display("[TB] 300 cache hits, some with both hit lines high");
        for (int i = 0; i < 300; i++) begin
            offerQ.push_back(makeTxn(1'($urandom), 5'($urandom), 8'($urandom), 8'($urandom),
                                     1, (i % 3 == 2) ? 2 : 0));
        end
        runUntilDrained("t6", 2500);
        check("t6_hits",   32'(cont_hits_out),   32'(255));
        check("t6_misses", 32'(cont_misses_out), 32'(0));

        $display("[TB] random traffic");
        offerPct = 60;
        for (int i = 0; i < 150; i++) begin
            int lat;
            lat = ($urandom_range(9) < 6) ? int'($urandom_range(3, 1)) : int'($urandom_range(MAX_WAIT + 2, 1));
            offerQ.push_back(makeTxn(1'($urandom), 5'($urandom), 8'($urandom), 8'($urandom),
                                     lat, int'($urandom_range(2))));
        end
        runUntilDrained("t7", 6000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controlador_acessos.md
Name: controlador_acessos

Overview:
- Upstream request sequencer for the memoria subsystem (cacheL1 + memoriaPrincipal).
- Accepts read/write requests from the processor side through a valid/ready handshake and buffers them in a small FIFO.
- Issues one request at a time to memoria and holds it until memoria reports a hit (cache or main memory) or a timeout expires.
- Returns a one-cycle response and keeps saturating hit/miss statistics.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- MAX_WAIT, 8, WAIT cycles allowed before a transaction is aborted with an error.

Ports:
- clock_in  input  1  system clock; all logic on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- req_valid_in  input  1  request present.
- req_ready_out  output  1  FIFO can accept; equals not-full.
- req_wren_in  input  1  1 = write, 0 = read.
- req_endereco_in  input  5  request address.
- req_data_in  input  8  write data.
- mem_wren_out  output  1  to memoria wren_in.
- mem_endereco_out  output  5  to memoria endereco_in.
- mem_data_out  output  8  to memoria data_in.
- mem_q_in  input  8  from memoria q_out.
- mem_hit_cache_in  input  1  from memoria hit_cache_out.
- mem_hit_memPrin_in  input  1  from memoria hit_memPrin_out.
- resp_valid_out  output  1  one-cycle response pulse.
- resp_data_out  output  8  read data; write echoes the written data.
- resp_hit_cache_out  output  1  1 = served by cache, 0 = served by main memory.
- resp_erro_out  output  1  timeout abort; qualified by resp_valid_out.
- busy_out  output  1  state is not IDLE, or FIFO is non-empty.
- cont_hits_out  output  8  saturating cache-hit count.
- cont_misses_out  output  8  saturating miss count (memPrin hits plus timeouts).

Behaviour:
- Reset:
  - FIFO emptied; state IDLE.
  - All outputs 0, except req_ready_out = 1.
  - Counters 0, wait counter 0.
  - Reset mid-transaction drops the transaction and all queued requests, with no response.
- FIFO:
  - Push when req_valid_in && req_ready_out.
  - Pop when IDLE && non-empty.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - When full, ready = 0 and the request is held upstream; the FIFO never overwrites.
  - Pointers wrap modulo DEPTH; a separate count (log2(DEPTH)+1 bits) resolves full vs empty.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into the transaction register, clear the wait counter, go to ISSUE.
  - ISSUE (1 cycle): drive mem_* from the transaction register, go to WAIT.
  - WAIT: mem_* held stable. Sample the hit inputs every cycle.
    - mem_hit_cache_in = 1: capture mem_q_in for a read (req data for a write), hit flag = 1, increment cont_hits, go to RESP.
    - Otherwise mem_hit_memPrin_in = 1: capture the same way, hit flag = 0, increment cont_misses, go to RESP.
    - Both hit inputs high: cache wins.
    - Neither high: increment the wait counter. When it reaches MAX_WAIT, set erro, resp_data = 0, increment cont_misses, go to RESP.
  - RESP: resp_valid_out = 1 for exactly one cycle with data/hit/erro stable; mem_wren_out = 0; go to IDLE.
- mem_* outputs are registered. mem_wren_out = 1 only during ISSUE/WAIT of a write; 0 in IDLE and RESP. mem_endereco_out and mem_data_out keep their last value outside a transaction.
- resp_* registered. Outside the RESP cycle, resp_valid_out = 0; data, hit and erro hold their last values.
- Counters saturate at 255 and never wrap.
- Minimum latency: request accepted at edge 0 into an idle, empty block; hit on the first WAIT cycle; resp_valid_out high in the cycle after edge 4.
- Throughput: at most one transaction every 4 cycles.
- Requests complete strictly in order.

Decomposition:
- Shared include acesso_defs.vh holds:
  - FSM state encodings (IDLE, ISSUE, WAIT, RESP).
  - Address width 5 and data width 8, so they match memoria.
  - Counter saturation value.
- Sub-module fifo_requisicoes (parameter DEPTH, width 14 = wren+addr+data) provides push/pop/full/empty.
- FSM, timeout counter and statistics stay in controlador_acessos.

Test Plan:
- Single read, addr 5'h03, mem_hit_cache_in = 1 on the first WAIT cycle with mem_q_in = 8'hA5 -> resp_valid 1 cycle after edge 4, resp_data A5, resp_hit_cache 1, cont_hits 1.
- Write, addr 5'h1F, data 8'h3C, mem_hit_memPrin_in on the 3rd WAIT cycle -> mem_wren_out high through ISSUE/WAIT, resp_data 3C, hit_cache 0, cont_misses 1.
- Push 5 back-to-back requests with DEPTH = 4 and memoria stalled -> req_ready_out low after the queue fills, the fifth is held and accepted later, all responses in issue order.
- No hit ever with MAX_WAIT = 8 -> resp_erro 1, resp_data 00 after 8 WAIT cycles, cont_misses 1; the next queued request then proceeds normally.
- Assert reset_in during WAIT with 2 requests queued -> next cycle: idle, FIFO empty, req_ready 1, mem_wren 0, counters 0, no resp_valid.
- 300 cache hits -> cont_hits saturates at 255; both hit inputs high at once -> counted as a cache hit only.
